// File: rtl/instr_encode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encode_queue
//  Brief    : Packs decoded RV32I fields into instruction words, queues them
//             and presents the two oldest entries on a dual-issue port.
//             Unknown opcodes are replaced by NOP and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encode_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_op,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [11:0]              in_imm12,
    input  logic [19:0]              in_imm20,
    output logic                     out0_valid,
    output logic [31:0]              out0_instr,
    output logic                     out1_valid,
    output logic [31:0]              out1_instr,
    input  logic [1:0]               deq_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic                     illegal_seen
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i_imme = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_s      = 7'b0100011;
    localparam logic [6:0] c_op_b      = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic [31:0]          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [CNT_W-1:0]     r_illegal_cnt;
    logic                 r_illegal_seen;

    logic                 w_ready;
    logic                 w_push;
    logic [1:0]           w_deq_req;
    logic [c_cnt_w-1:0]   w_pop;
    logic [31:0]          w_word;
    logic                 w_illegal;
    logic [c_ptr_w-1:0]   w_rd_ptr_p1;

    // Acceptance depends only on registered occupancy; a flush cycle discards the push
    always_comb begin
        w_ready = (r_count < c_cnt_w'(DEPTH));
        w_push  = in_valid && w_ready && !flush;
    end

    // Pop amount: request of 3 means 2, and never more than what is queued
    always_comb begin
        w_deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        w_pop     = (c_cnt_w'(w_deq_req) > r_count) ? r_count : c_cnt_w'(w_deq_req);
    end

    // Field packer: rebuilds the RV32I word from the decoded fields
    always_comb begin
        w_word    = c_nop;
        w_illegal = 1'b0;
        case (in_op)
            c_op_r:
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            c_op_i_imme:
                if (in_funct3 == 3'd1 || in_funct3 == 3'd5)
                    // shifts carry funct7 above a 5-bit shamt
                    w_word = {in_funct7, in_imm12[4:0], in_rs1, in_funct3, in_rd, in_op};
                else
                    w_word = {in_imm12, in_rs1, in_funct3, in_rd, in_op};
            c_op_load:
                w_word = {in_imm12, in_rs1, in_funct3, in_rd, in_op};
            c_op_s:
                w_word = {in_imm12[11:5], in_rs2, in_rs1, in_funct3, in_imm12[4:0], in_op};
            c_op_b:
                // imm12 holds offset bits [12:1]
                w_word = {in_imm12[11], in_imm12[9:4], in_rs2, in_rs1, in_funct3,
                          in_imm12[3:0], in_imm12[10], in_op};
            c_op_jal:
                // imm20 holds offset bits [20:1]
                w_word = {in_imm20[19], in_imm20[9:0], in_imm20[10], in_imm20[18:11],
                          in_rd, in_op};
            default: begin
                w_word    = c_nop;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Queue bookkeeping: occupancy and wrapping pointers, flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + c_cnt_w'(w_push) - w_pop;
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(w_pop);
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_push);
        end
    end

    // Entry storage; contents beyond occupancy are never visible, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_word;
    end

    // Illegal-opcode statistics: saturating count plus sticky flag, immune to flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt  <= '0;
            r_illegal_seen <= 1'b0;
        end else if (w_push && w_illegal) begin
            r_illegal_seen <= 1'b1;
            if (r_illegal_cnt != {CNT_W{1'b1}})
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    // Dual-issue view of the two oldest entries, zeroed when absent
    always_comb begin
        w_rd_ptr_p1  = r_rd_ptr + c_ptr_w'(1);
        out0_valid   = (r_count >= c_cnt_w'(1));
        out1_valid   = (r_count >= c_cnt_w'(2));
        out0_instr   = out0_valid ? r_mem[r_rd_ptr]    : 32'h0;
        out1_instr   = out1_valid ? r_mem[w_rd_ptr_p1] : 32'h0;
        in_ready     = w_ready;
        count        = r_count;
        illegal_cnt  = r_illegal_cnt;
        illegal_seen = r_illegal_seen;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encode_queue
//  Brief    : Self-checking bench for instr_encode_queue with a queue-based
//             reference model, randomized traffic and literal anchor checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encode_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [11:0] in_imm12 = '0;
    logic [19:0] in_imm20 = '0;
    logic        out0_valid;
    logic [31:0] out0_instr;
    logic        out1_valid;
    logic [31:0] out1_instr;
    logic [1:0]  deq_cnt = '0;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0] illegal_cnt;
    logic        illegal_seen;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [31:0] m_q[$];
    int          m_ill  = 0;
    bit          m_seen = 1'b0;

    instr_encode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm12(in_imm12), .in_imm20(in_imm20),
        .out0_valid(out0_valid), .out0_instr(out0_instr),
        .out1_valid(out1_valid), .out1_instr(out1_instr),
        .deq_cnt(deq_cnt), .count(count),
        .illegal_cnt(illegal_cnt), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding from the ISA's view: B/J offsets are rebuilt as full byte offsets first
    function automatic logic [31:0] model_encode(input logic [6:0] op, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [11:0] i12, input logic [19:0] i20,
            output bit illegal);
        logic [12:0] boff;
        logic [20:0] joff;
        boff = {i12, 1'b0};
        joff = {i20, 1'b0};
        illegal = 1'b0;
        case (op)
            7'h33: return {f7, rs2, rs1, f3, rd, op};
            7'h13: return (f3 == 3'd1 || f3 == 3'd5) ? {f7, i12[4:0], rs1, f3, rd, op}
                                                     : {i12, rs1, f3, rd, op};
            7'h03: return {i12, rs1, f3, rd, op};
            7'h23: return {i12[11:5], rs2, rs1, f3, i12[4:0], op};
            7'h63: return {boff[12], boff[10:5], rs2, rs1, f3, boff[4:1], boff[11], op};
            7'h6F: return {joff[20], joff[10:1], joff[11], joff[19:12], rd, op};
            default: begin
                illegal = 1'b1;
                return 32'h0000_0013;
            end
        endcase
    endfunction

    // Model update: pop oldest entries, append new word, account for illegal pushes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ill  = 0;
            m_seen = 1'b0;
        end else begin
            bit ready, push, ill;
            int req, pop;
            logic [31:0] w;
            ready = (m_q.size() < DEPTH);
            push  = in_valid && ready;
            req   = (deq_cnt == 2'd3) ? 2 : int'(deq_cnt);
            pop   = (req < m_q.size()) ? req : m_q.size();
            w = model_encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
                             in_imm12, in_imm20, ill);
            if (flush) begin
                m_q.delete();
            end else begin
                for (int i = 0; i < pop; i++) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(w);
                    if (ill) begin
                        m_seen = 1'b1;
                        if (m_ill < (1 << CNT_W) - 1) m_ill++;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("count",    32'(count),       32'(m_q.size()));
            check("in_ready", 32'(in_ready),    32'(m_q.size() < DEPTH));
            check("out0_vld", 32'(out0_valid),  32'(m_q.size() >= 1));
            check("out1_vld", 32'(out1_valid),  32'(m_q.size() >= 2));
            check("out0_ins", out0_instr,       (m_q.size() >= 1) ? m_q[0] : 32'h0);
            check("out1_ins", out1_instr,       (m_q.size() >= 2) ? m_q[1] : 32'h0);
            check("ill_cnt",  32'(illegal_cnt), 32'(m_ill));
            check("ill_seen", 32'(illegal_seen), 32'(m_seen));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        deq_cnt  = 2'd0;
        flush    = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
            input logic [11:0] i12, input logic [19:0] i20);
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm12 = i12; in_imm20 = i20;
    endtask

    task automatic drive_random();
        logic [6:0] op;
        case ($urandom_range(0, 7))
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4: op = 7'h63;
            5: op = 7'h6F;
            6: op = 7'h7F;
            default: op = 7'($urandom_range(0, 127));
        endcase
        drive(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
              7'($urandom), 12'($urandom), 20'($urandom));
    endtask

    initial begin
        // reset, values held while in reset
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #20;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out0",  out0_instr, 32'h0);
        check("rst_ill",   32'(illegal_cnt), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // ADDI into empty queue
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 20'd0);
        tick(); idle();
        check("addi_v",   32'(out0_valid), 32'd1);
        check("addi_ins", out0_instr, 32'h0050_0093);
        check("addi_cnt", 32'(count), 32'd1);

        // ADD lands on out1, then dual pop
        drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 20'd0);
        tick(); idle();
        check("add_ins", out1_instr, 32'h0020_81B3);
        check("add_v",   32'(out1_valid), 32'd1);
        deq_cnt = 2'd2;
        tick(); idle();
        check("pop2_cnt", 32'(count), 32'd0);
        check("pop2_v",   32'(out0_valid | out1_valid), 32'd0);

        // SW, BEQ, JAL, SRAI back to back
        drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'd8, 20'd0);     tick();
        drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'h004, 20'd0);   tick();
        drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 20'd8);     tick();
        drive(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 12'd3, 20'd0);    tick();
        idle();
        check("sw_ins",  out0_instr, 32'h0020_A423);
        check("beq_ins", out1_instr, 32'h0020_8463);
        deq_cnt = 2'd2; tick(); idle();
        check("jal_ins",  out0_instr, 32'h0100_00EF);
        check("srai_ins", out1_instr, 32'h4033_5293);
        deq_cnt = 2'd2; tick(); idle();

        // illegal opcodes become NOP and are counted
        drive(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0, 20'd0);
        tick(); idle();
        check("ill_nop",  out0_instr, 32'h0000_0013);
        check("ill_cnt1", 32'(illegal_cnt), 32'd1);
        check("ill_seen", 32'(illegal_seen), 32'd1);
        drive(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0, 20'd0);
        tick(); idle();
        check("ill_cnt2", 32'(illegal_cnt), 32'd2);
        deq_cnt = 2'd3; tick(); idle();

        // fill to full, then a push alongside a pop is still refused
        for (int i = 0; i < DEPTH; i++) begin
            drive(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 12'(i), 20'd0);
            tick();
        end
        check("full_cnt", 32'(count), 32'd8);
        check("full_rdy", 32'(in_ready), 32'd0);
        deq_cnt = 2'd1;
        tick();
        check("held_cnt", 32'(count), 32'd7);
        deq_cnt = 2'd0;
        tick(); idle();
        check("refill_cnt", 32'(count), 32'd8);

        // randomized push/pop traffic exercising wrap
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) drive_random(); else in_valid = 1'b0;
            deq_cnt = 2'($urandom_range(0, 3));
            flush   = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();

        // drain with a bounded loop
        for (int i = 0; i < 2 * DEPTH && count != 0; i++) begin
            deq_cnt = 2'd3;
            tick();
        end
        idle();
        check("drain_cnt", 32'(count), 32'd0);

        // over-pop from a single entry
        drive(7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 12'd0, 20'd0);
        tick(); idle();
        deq_cnt = 2'd2;
        tick(); idle();
        check("overpop_cnt", 32'(count), 32'd0);

        // flush beats a simultaneous illegal push
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd1, 20'd0); tick();
        drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 12'd2, 20'd0); tick();
        begin
            int ill_before;
            ill_before = m_ill;
            drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 20'd0);
            flush = 1'b1;
            tick(); idle();
            check("flush_cnt", 32'(count), 32'd0);
            check("flush_ill", 32'(illegal_cnt), 32'(ill_before));
        end

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_v0",  32'(out0_valid), 32'd0);
        check("arst_i0",  out0_instr, 32'h0);
        check("arst_v1",  32'(out1_valid), 32'd0);
        check("arst_i1",  out1_instr, 32'h0);
        check("arst_cnt", 32'(count), 32'd0);
        check("arst_ill", 32'(illegal_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
